// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit with HI/LO result registers.
// Each operation takes 32 shift-add or restoring-divide steps followed by one
// sign-fix step. The unit reports busy while it works and pulses done once the
// result is in HI/LO. While the unit is idle, HI and LO can also be written directly.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [63:0] acc;        // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [31:0] operand;    // multiply: multiplicand magnitude; divide: divisor magnitude
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;

    logic        accept;
    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] acc_step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes at capture time, plus one multiply or divide step on acc.
    always_comb begin
        accept    = (state == S_IDLE) && start;
        signed_op = ~op[0];
        mag_a     = (signed_op && a[31]) ? -a : a;
        mag_b     = (signed_op && b[31]) ? -b : b;
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
        div_shift = acc[63:31];
        div_ge    = div_shift >= {1'b0, operand};
        div_diff  = div_shift[31:0] - operand;
        acc_step  = '0;
        if (is_div) begin
            // A failed trial subtraction only shifts, so the remainder is restored for free.
            if (div_ge) acc_step = {div_diff, acc[30:0], 1'b1};
            else        acc_step = {acc[62:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    // Sign correction of the raw magnitude result; divide-by-zero forces an all-ones quotient.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
        quo_fix  = '1;
        if (!div_zero) quo_fix = neg_res ? -acc[31:0] : acc[31:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) state_next = S_ITER;
            S_ITER:  if (cnt == 6'd31) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration counter and datapath accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            is_div   <= op[1];
            neg_res  <= signed_op && (a[31] ^ b[31]);
            neg_rem  <= signed_op && a[31] && op[1];
            div_zero <= op[1] && (b == 32'd0);
            operand  <= op[1] ? mag_b : mag_a;
            acc      <= op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
        end else if (state == S_ITER) begin
            cnt <= cnt + 6'd1;
            acc <= acc_step;
        end else if (state == S_FIX) begin
            cnt <= '0;
        end
    end

    // HI/LO registers: result load at the end of FIX, direct writes only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == S_FIX) begin
            if (is_div) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end else begin
                hi <= prod_fix[63:32];
                lo <= prod_fix[31:0];
            end
        end else if (state == S_IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

    // One-cycle completion pulse following the result load.
    always_ff @(posedge clk) begin
        if (reset) done <= 1'b0;
        else       done <= (state == S_FIX);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; afterwards the unit must be busy.
    task automatic launch(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        check({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for done; 'elapsed' is the number of steps already taken after the accept edge.
    task automatic wait_done(input string tag, input int elapsed, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        int busy_n;
        lat    = elapsed;
        busy_n = elapsed;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    initial begin : stimulus
        int  stray;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        // MULT -3 * 7 = -21
        launch("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7);
        wait_done("mult_neg", 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        step();
        check("mult_neg_done_one_cycle", {31'd0, done}, 32'd0);
        check("mult_neg_hi_hold", hi, 32'hFFFFFFFF);
        check("mult_neg_lo_hold", lo, 32'hFFFFFFEB);

        // MULTU (2^32-1)^2 = 0xFFFFFFFE_00000001
        launch("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_max", 0, 32'hFFFFFFFE, 32'h00000001);

        // DIV -7 / 2 = -3 rem -1, then DIVU 7 / 0 launched in the done cycle
        launch("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        launch("divu_zero", 2'b11, 32'd7, 32'd0);
        wait_done("divu_zero", 0, 32'd7, 32'hFFFFFFFF);

        // DIV -8 / 0: quotient all ones, remainder equals dividend
        launch("div_zero", 2'b10, 32'hFFFFFFF8, 32'd0);
        wait_done("div_zero", 0, 32'hFFFFFFF8, 32'hFFFFFFFF);

        // DIV 7 / -2 = -3 rem 1
        launch("div_negb", 2'b10, 32'd7, 32'hFFFFFFFE);
        wait_done("div_negb", 0, 32'd1, 32'hFFFFFFFD);

        // DIV most-negative / -1 wraps to most-negative
        launch("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 0, 32'd0, 32'h80000000);
        step();

        // DIVU 100 / 7 with start, operand changes and wr_lo while busy
        launch("divu_busy", 2'b11, 32'd100, 32'd7);
        step();
        step();
        step();
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd1;
        b     = 32'd1;
        wr_lo = 1'b1;
        wdata = 32'd5;
        step();
        start = 1'b0;
        wr_lo = 1'b0;
        a     = 32'd123;
        b     = 32'd9;
        check("divu_busy_wr_lo_ignored", lo, 32'h80000000);
        wait_done("divu_busy", 4, 32'd2, 32'd14);
        step();
        check("divu_busy_no_queue", {31'd0, busy}, 32'd0);
        check("divu_busy_done_low", {31'd0, done}, 32'd0);

        // start coinciding with wr_hi in IDLE: write lands, then result overwrites
        wr_hi = 1'b1;
        wdata = 32'hDEADBEEF;
        launch("start_wr", 2'b01, 32'd5, 32'd6);
        wr_hi = 1'b0;
        check("start_wr_hi_written", hi, 32'hDEADBEEF);
        wait_done("start_wr", 0, 32'd0, 32'd30);

        // MULTU 3*4, then DIVU reset mid-iteration
        launch("multu_small", 2'b01, 32'd3, 32'd4);
        wait_done("multu_small", 0, 32'd0, 32'd12);
        launch("divu_reset", 2'b11, 32'd50, 32'd5);
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        stray = 0;
        repeat (40) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        check("abort_no_activity", 32'(stray), 32'd0);

        // Direct writes in IDLE
        wr_hi = 1'b1;
        wdata = 32'hA5A5A5A5;
        step();
        wr_hi = 1'b0;
        check("wr_hi_idle_hi", hi, 32'hA5A5A5A5);
        check("wr_hi_idle_lo", lo, 32'd0);
        wr_lo = 1'b1;
        wdata = 32'h00001234;
        step();
        wr_lo = 1'b0;
        check("wr_lo_idle_lo", lo, 32'h00001234);
        check("wr_lo_idle_hi", hi, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to launch an operation; accepted only when busy=0.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  first operand (multiplicand or dividend).
REQ-007 b  input  32  second operand (multiplier or divisor).
REQ-008 wr_hi  input  1  move-to-HI strobe.
REQ-009 wr_lo  input  1  move-to-LO strobe.
REQ-010 wdata  input  32  data for wr_hi and wr_lo.
REQ-011 hi  output  32  HI register (product upper word or remainder).
REQ-012 lo  output  32  LO register (product lower word or quotient).
REQ-013 busy  output  1  an operation is in progress; the pipeline stalls on it.
REQ-014 done  output  1  one-cycle pulse indicating that hi and lo hold a new result.

Function
REQ-015 The block SHALL implement the state machine IDLE -> ITER (32 cycles) -> FIX (1 cycle) -> IDLE, with a 6-bit iteration counter.
REQ-016 In IDLE, start=1 at a rising edge SHALL capture a, b and op and enter ITER; a, b and op changes after capture SHALL have no effect.
REQ-017 busy SHALL be 1 in every ITER and FIX cycle and 0 in IDLE, so busy is high for exactly 33 cycles after acceptance.
REQ-018 start asserted while busy=1 SHALL be ignored, and no request SHALL be queued.
REQ-019 MULT/MULTU SHALL use 32 iterations of shift-add on operand magnitudes; signed operands SHALL be converted to magnitudes at capture.
REQ-020 DIV/DIVU SHALL use 32 iterations of restoring division on operand magnitudes.
REQ-021 In FIX, a signed multiply SHALL negate the 64-bit product when the operand signs differ.
REQ-022 In FIX, a signed divide SHALL negate the quotient when the operand signs differ, and SHALL give the remainder the sign of the dividend.
REQ-023 At the rising edge ending FIX, hi and lo SHALL be loaded: product[63:32]/product[31:0] for multiply, remainder/quotient for divide.
REQ-024 done SHALL be 1 for exactly the one cycle following that load edge; busy SHALL be 0 in that same cycle, and a start in that cycle SHALL be accepted.
REQ-025 Divide by zero (both DIV and DIVU) SHALL yield lo=32'hFFFFFFFF and hi=a, with no exception and the same 34-edge latency.
REQ-026 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL yield lo=32'h80000000 and hi=0.
REQ-027 wr_hi or wr_lo SHALL update the addressed register from wdata at the edge only when busy=0.
REQ-028 wr_hi and wr_lo asserted while busy=1 SHALL be ignored.
REQ-029 When start and wr_hi/wr_lo coincide in IDLE, the write and the start SHALL both take effect; the later result overwrites hi and lo.
REQ-030 hi and lo SHALL hold their values in all cycles other than a load or write edge.

Reset
REQ-031 reset=1 at a rising edge SHALL force state IDLE, counter=0, busy=0, done=0, hi=0 and lo=0.
REQ-032 Reset SHALL take priority over start, wr_hi and wr_lo.
REQ-033 Reset during ITER or FIX SHALL abandon the operation with no done pulse and no hi/lo update other than clearing.

Verification
REQ-034 MULT a=32'hFFFFFFFD, b=7 -> done exactly 34 cycles after the accept edge, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-035 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-036 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; then DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-037 DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-038 DIVU 100/7, then at cycle 5 assert start=1 with op=MULT, a=1, b=1 and change a/b; also pulse wr_lo=1 with wdata=5 while busy -> all ignored; result lo=14, hi=2.
REQ-039 Back-to-back sequence: MULTU 3*4, then reset at cycle 10 of a following DIVU -> hi=lo=0 and busy=0 next cycle, no done pulse; then wr_hi=1 with wdata=32'hA5A5A5A5 in IDLE -> hi=32'hA5A5A5A5.
